// File: rtl/onehot_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decode_pipe
// Description : Decodes 3-bit binary codes to 8-bit one-hot words through a
//               2-entry valid/ready FIFO. It counts delivered words in an
//               8-bit wrapping counter. When the DEC_ACCUM_EN macro is
//               defined, it also keeps a sticky OR of delivered words
//               (ports seen / seen_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_decode_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] in_code,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       en,
    output logic [7:0] out_onehot,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] dec_cnt
`ifdef DEC_ACCUM_EN
    ,
    input  logic       seen_clr,
    output logic [7:0] seen
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_head;     // oldest buffered code, presented at the output
    logic [2:0] r_tail;     // second code, valid only in FULL
    logic [7:0] r_dec_cnt;
    logic       w_accept;
    logic       w_pop;

    // Reset gating keeps in_ready low for the whole time rst_n is asserted,
    // even though the state already reads EMPTY then.
    assign in_ready   = rst_n && en && (r_state != FULL);
    assign out_valid  = (r_state != EMPTY);
    assign out_onehot = out_valid ? (8'h01 << r_head) : 8'h00;
    assign dec_cnt    = r_dec_cnt;

    assign w_accept = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next occupancy from accept/pop of this cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (w_accept) w_state_nxt = ONE;
            end
            ONE: begin
                if (w_accept && !w_pop)      w_state_nxt = FULL;
                else if (!w_accept && w_pop) w_state_nxt = EMPTY;
            end
            FULL: begin
                if (w_pop) w_state_nxt = ONE;
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // FIFO storage: head is always the oldest entry; tail shifts into head on pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= 3'b000;
            r_tail <= 3'b000;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) r_head <= in_code;
                end
                ONE: begin
                    if (w_accept && w_pop)   r_head <= in_code;
                    else if (w_accept)       r_tail <= in_code;
                end
                FULL: begin
                    if (w_pop) r_head <= r_tail;
                end
                default: begin
                    r_head <= 3'b000;
                end
            endcase
        end
    end

    // Completed output handshakes, wrapping at 8 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_cnt <= 8'h00;
        end else if (w_pop) begin
            r_dec_cnt <= r_dec_cnt + 8'h01;
        end
    end

`ifdef DEC_ACCUM_EN
    logic [7:0] r_seen;

    assign seen = r_seen;

    // Sticky OR of delivered words; a clear that lands on a delivery keeps
    // only that delivered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen <= 8'h00;
        end else if (seen_clr) begin
            r_seen <= w_pop ? out_onehot : 8'h00;
        end else if (w_pop) begin
            r_seen <= r_seen | out_onehot;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/onehot_decode_pipe.md
ONEHOT_DECODE_PIPE -- requirements
Module: onehot_decode_pipe

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: in_code  input  3  binary code to decode (000..111).
REQ-004 SHALL have port: in_valid  input  1  in_code is valid this cycle.
REQ-005 SHALL have port: in_ready  output  1  block accepts in_code this cycle.
REQ-006 SHALL have port: en  input  1  decode enable; low stalls input acceptance.
REQ-007 SHALL have port: out_onehot  output  8  one-hot decode of head entry.
REQ-008 SHALL have port: out_valid  output  1  out_onehot is valid.
REQ-009 SHALL have port: out_ready  input  1  downstream accepts out_onehot.
REQ-010 SHALL have port: dec_cnt  output  8  count of completed output handshakes.
REQ-011 SHALL have ports seen (output, 8, sticky OR of delivered words) and seen_clr (input, 1, synchronous clear), present only when DEC_ACCUM_EN is defined.

Function
REQ-012 SHALL accept input on any rising edge where in_valid && in_ready; SHALL pop output where out_valid && out_ready.
REQ-013 SHALL buffer accepted codes in a 2-entry FIFO; occupancy FSM states EMPTY, ONE, FULL.
REQ-014 SHALL transition: EMPTY->ONE on accept; ONE->FULL on accept without pop; ONE->EMPTY on pop without accept; ONE->ONE on simultaneous accept and pop; FULL->ONE on pop.
REQ-015 SHALL drive in_ready = en && (state != FULL), combinational from state and en only (no dependency on out_ready).
REQ-016 SHALL drive out_valid = (state != EMPTY), registered-state-derived.
REQ-017 SHALL drive out_onehot = 8'h01 << head code when out_valid; exactly one bit set; bit index equals code (code 3'b101 -> 8'b0010_0000).
REQ-018 SHALL drive out_onehot = 8'h00 when state is EMPTY.
REQ-019 SHALL have latency one cycle: code accepted at edge N appears on out_onehot with out_valid high immediately after edge N.
REQ-020 SHALL preserve order: codes leave in acceptance order; none lost or duplicated.
REQ-021 SHALL hold out_onehot stable while out_valid && !out_ready.
REQ-022 SHALL, in FULL, ignore in_valid (in_ready low); simultaneous pop in FULL yields ONE, with no new accept that edge.
REQ-023 SHALL, when en falls, stop accepting but continue draining buffered entries to output.
REQ-024 SHALL increment dec_cnt by 1 on each output handshake, 8-bit, wrapping 8'hFF -> 8'h00.

Reset
REQ-025 SHALL, on rst_n low, immediately (asynchronously) force state EMPTY, FIFO contents 3'b000, out_valid 0, out_onehot 8'h00, dec_cnt 8'h00, seen 8'h00 (if present); in_ready SHALL be 0 while rst_n low.
REQ-026 SHALL discard buffered entries when reset asserts mid-operation; first edge after rst_n release behaves as EMPTY.

Configuration
REQ-027 SHALL use macro DEC_ACCUM_EN to compile in the sticky accumulator.
REQ-028 SHALL, with DEC_ACCUM_EN defined, update seen <= seen | out_onehot on each output handshake; seen_clr high sets seen <= 8'h00; seen_clr coincident with handshake yields seen <= out_onehot.
REQ-029 SHALL, without DEC_ACCUM_EN, omit seen and seen_clr ports and logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: reset, en=1, out_ready=1, codes 0..7 one per cycle -> out_onehot 01,02,04,...,80 each one cycle after accept; dec_cnt=8.
REQ-031 SHALL cover: out_ready=0, push 3'b010, 3'b110 -> state FULL, in_ready=0, out_onehot held 8'h04; raise out_ready -> 8'h04 then 8'h40.
REQ-032 SHALL cover: FULL with in_valid=1 and out_ready=1 same cycle -> only pop, third code not accepted until next cycle.
REQ-033 SHALL cover: 256 handshakes -> dec_cnt wraps to 8'h00; en=0 with 1 entry buffered -> entry still delivered, no new accept.
REQ-034 SHALL cover: rst_n low mid-stream with FULL -> out_valid 0, out_onehot 8'h00 without clock edge; after release first code decodes normally.
REQ-035 SHALL cover (DEC_ACCUM_EN): deliver codes 1,3 -> seen 8'h0A; seen_clr with delivery of code 7 -> seen 8'h80.
